mw_cla_seq: RTL and testbench

//  Multi-cycle sequencer for wide add/subtract on one shared 16-bit CLA datapath.

---
 rtl/mw_cla_seq_pkg.sv | 16 +
 rtl/mw_cla_seq_cla.sv | 41 ++++
 rtl/mw_cla_seq.sv | 137 +++++++++++++
 tb/tb_mw_cla_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mw_cla_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer: FSM encodings, slice width
// and the signed-overflow rule applied to the top slice.
package mw_cla_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CLA_SLICE_W = 16;

    // Overflow when both addends share a sign and the result sign differs from it.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mw_cla_seq_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level
// across the group generate/propagate terms.
module sixteen_bit_cla (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign gg[k]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k]  = &p[B+3:B];
        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & gc[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
    end

    assign gc[0] = cin_i;
    assign gc[1] = gg[0] | (gp[0] & gc[0]);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & gc[0]);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

    assign sum_o  = p ^ c;
    assign cout_o = gc[4];

endmodule

// File: rtl/mw_cla_seq.sv
// Wide add/subtract sequencer: one 16-bit CLA slice per cycle, carry chained through
// a register, result presented on a valid/ready handshake.
module mw_cla_seq
    import mw_cla_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / CLA_SLICE_W;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;

    logic [CLA_SLICE_W-1:0] cla_sum;
    logic                   cla_cout;
    logic                   last_slice;
    logic [WIDTH-1:0]       sum_full;

    sixteen_bit_cla u_cla (
        .a_i    (a_q[CLA_SLICE_W-1:0]),
        .b_i    (b_q[CLA_SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (cla_sum),
        .cout_o (cla_cout)
    );

    // Earlier slices collect here, newest on top; the visible result only updates on
    // the final slice so a partial sum is never exposed.
    if (NSLICE > 1) begin : g_multi
        logic [WIDTH-CLA_SLICE_W-1:0] sh_q, sh_d;

        assign sum_full = {cla_sum, sh_q};

        always_comb begin
            sh_d = sh_q;
            if (state_q == S_RUN) sh_d = sum_full[WIDTH-1:CLA_SLICE_W];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sh_q <= '0;
            else        sh_q <= sh_d;
        end
    end else begin : g_single
        assign sum_full = cla_sum;
    end

    assign last_slice = (idx_q == IDXW'(NSLICE - 1));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CLA_SLICE_W;
                b_d     = b_q >> CLA_SLICE_W;
                carry_d = cla_cout;
                idx_d   = idx_q + 1'b1;
                if (last_slice) begin
                    out_sum_d  = sum_full;
                    out_cout_d = cla_cout;
                    out_ovf_d  = signed_ovf(a_q[CLA_SLICE_W-1], b_q[CLA_SLICE_W-1],
                                            cla_sum[CLA_SLICE_W-1]);
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mw_cla_seq.sv
// Directed and randomized checks of mw_cla_seq (WIDTH=64) against an arithmetic model.
module tb_mw_cla_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [63:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [63:0] out_sum;
    logic        out_cout, out_ovf, busy;

    int n_assert = 0;
    int n_fail   = 0;

    mw_cla_seq #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic s);
        logic [64:0] u;
        logic [64:0] r;
        logic        co;
        if (s) begin
            u  = {1'b0, a - b};
            co = (a >= b);
            r  = {a[63], a} - {b[63], b};
        end else begin
            u  = {1'b0, a} + {1'b0, b};
            co = u[64];
            r  = {a[63], a} + {b[63], b};
        end
        return {(r[64] != r[63]), co, u[63:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for out_valid; lat = edges from accept to out_valid.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        chk("accept_ready", in_ready, 1'b1);
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [65:0] e;
        logic [63:0] hold_sum;
        logic        hold_c, hold_o;
        logic [63:0] corner [4];
        logic [65:0] sbq [$];
        logic [63:0] ra, rb;
        logic        rsub, have_op;
        int          accepted, results, cyc;

        corner[0] = 64'h0;
        corner[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        corner[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        corner[3] = 64'h8000_0000_0000_0000;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 64'h0);
        chk("rst_cout_ovf", {out_cout, out_ovf}, 2'b00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Max + 1 wraps, with latency check
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        chk("t1_latency", 64'(lat), 64'd4);
        chk("t1_sum", out_sum, 64'h0);
        chk("t1_cout_ovf", {out_cout, out_ovf}, 2'b10);
        release_result();

        do_op(64'h0, 64'h1, 1'b1, lat);
        chk("t2_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_cout_ovf", {out_cout, out_ovf}, 2'b00);
        release_result();

        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        chk("t3a_sum", out_sum, 64'h8000_0000_0000_0000);
        chk("t3a_cout_ovf", {out_cout, out_ovf}, 2'b01);
        release_result();

        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, lat);
        chk("t3b_sum", out_sum, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t3b_cout_ovf", {out_cout, out_ovf}, 2'b11);
        release_result();

        // Subtract zero: A back, no borrow
        do_op(64'h0123_4567_89AB_CDEF, 64'h0, 1'b1, lat);
        chk("sub0_sum", out_sum, 64'h0123_4567_89AB_CDEF);
        chk("sub0_cout_ovf", {out_cout, out_ovf}, 2'b10);
        release_result();

        // Backpressure in DONE with a stray request
        do_op(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, lat);
        hold_sum = out_sum; hold_c = out_cout; hold_o = out_ovf;
        chk("t4_sum", hold_sum, 64'h2020_3131_4242_5353);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            in_a = 64'hDEAD; in_b = 64'hBEEF;
            tick();
            chk("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_sum", out_sum, hold_sum);
            chk("t4_hold_flags", {out_cout, out_ovf}, {hold_c, hold_o});
            chk("t4_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        release_result();
        chk("t4_drop_valid", out_valid, 1'b0);
        chk("t4_idle_ready", in_ready, 1'b1);
        tick();
        chk("t4_no_capture", busy, 1'b0);
        chk("t4_sum_kept", out_sum, hold_sum);

        // Reset during the second RUN cycle
        in_a = 64'h5555; in_b = 64'h1; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_sum", out_sum, 64'h0);
        chk("t5_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(64'h1234, 64'h0001, 1'b0, lat);
        chk("t5_after_sum", out_sum, 64'h1235);
        chk("t5_after_lat", 64'(lat), 64'd4);
        release_result();

        // Randomized traffic against the model with a scoreboard
        accepted = 0; results = 0; cyc = 0; have_op = 1'b0;
        ra = '0; rb = '0; rsub = 1'b0;
        while ((accepted < 1000 || sbq.size() != 0) && cyc < 30000) begin
            if (!have_op && accepted < 1000) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if ($urandom_range(3) == 0) ra = corner[$urandom_range(3)];
                if ($urandom_range(3) == 0) rb = corner[$urandom_range(3)];
                rsub = 1'($urandom_range(1));
                have_op = 1'b1;
            end
            in_valid  = have_op && ($urandom_range(3) != 0);
            in_a = ra; in_b = rb; in_sub = rsub;
            out_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sbq.push_back(model(ra, rb, rsub));
                accepted++;
                have_op = 1'b0;
            end
            if (out_valid && out_ready) begin
                results++;
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("rand_sum", out_sum, e[63:0]);
                    chk("rand_cout", out_cout, e[64]);
                    chk("rand_ovf", out_ovf, e[65]);
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rand_results", 64'(results), 64'd1000);
        chk("rand_pending", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
